cs_resolve_serial: RTL and testbench
====================================

// Module: cs_resolve_serial
// PURPOSE
//  Consumer end of the carry-save compressor trees: takes one carry-save pair (sum vector S,
//  carry vector C) and resolves it into a plain binary result R = S + (C << 1) mod 2^WIDTH.
//  Resolution is chunk-serial: one CHUNK-bit ripple slice per cycle, with the carry held in a register.
//  Valid/ready handshakes on both sides. Sits after multi-operand CSA arrays where area beats latency.
// PARAMETERS
//  WIDTH  32  operand/result width in bits; WIDTH % CHUNK == 0, WIDTH >= 2
//  CHUNK   8  bits resolved per cycle; NCH = WIDTH/CHUNK chunks; CHUNK == WIDTH gives a 1-cycle resolve
// PORTS
//  clk_i       in   1      clock, rising edge
//  rst_ni      in   1      reset, asynchronous, active-low
//  in_valid_i  in   1      S/C pair valid
//  in_ready_o  out  1      block can accept; high only in IDLE
//  s_i         in   WIDTH  carry-save sum vector
//  c_i         in   WIDTH  carry-save carry vector, weight 2^(i+1) for bit i
//  out_valid_o out  1      res_o valid
//  out_ready_i in   1      downstream accepts res_o
//  res_o       out  WIDTH  resolved binary result
//  ovf_o       out  1      only with CSR_OVF_EN; true sum >= 2^WIDTH
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE, out_valid_o=0, res_o=0, ovf_o=0, carry reg=0, chunk cnt=0.
//    in_ready_o=1 during and after reset. A reset mid-RUN discards the operation; no output is produced.
//  - FSM states:
//    - IDLE: in_ready_o=1. On in_valid_i&&in_ready_o, register s_i and csh={c_i[WIDTH-2:0],1'b0}.
//      Register c_i[WIDTH-1] as the dropped top carry. Set cnt=0, cy=0, go to RUN.
//    - RUN, one cycle per chunk k=cnt: {cy', R[k]} = S[k] + csh[k] + cy.
//      Write R[k] into the result reg and set cy<=cy'. After the last chunk (cnt==NCH-1), go to DONE;
//      otherwise cnt++.
//    - DONE: out_valid_o=1, res_o stable until out_ready_i. On the handshake, go to IDLE and clear
//      out_valid_o in the next cycle.
//  - Latency: accept at edge t -> out_valid_o high after edge t+NCH. Throughput: one op per NCH+2 cycles.
//  - in_ready_o=0 in RUN and DONE; in_valid_i/s_i/c_i are ignored there. No same-cycle in/out overlap.
//  - res_o holds its last value in IDLE. Partial chunks are visible during RUN but are not valid.
//  - Upstream may drop in_valid_i without a handshake; nothing is captured.
//  - Arithmetic is modulo 2^WIDTH. The true sum can reach 3*2^WIDTH-3; only the ovf flag reports the excess.
//  - cnt width is $clog2(NCH) with a minimum of 1 bit. No wrap past NCH-1.
// CONFIGURATION
//  CSR_OVF_EN defined: port ovf_o is present. ovf = final cy | dropped top carry, registered at the
//    RUN->DONE transition and valid with out_valid_o.
//  Undefined: ovf_o port, flag register and top-carry register are all absent. res_o is unchanged.
// STRUCTURE
//  csr_pkg:
//    - typedef enum logic [1:0] {CSR_IDLE, CSR_RUN, CSR_DONE} csr_state_e
//    - function csr_nch(width, chunk)
//    - parameter-check constants
//  Sub-module csr_chunk_add #(CHUNK): combinational CHUNK-bit ripple adder (a, b, ci -> s, co),
//    built from FullAdder cells. The top level holds the FSM, registers and chunk mux/demux.
//  Elaboration assertion: WIDTH % CHUNK == 0.
// TESTING (WIDTH=32, CHUNK=8 unless noted)
//  1 s=0x000000FF, c=0x00000001 -> res=0x00000101, ovf=0. out_valid rises 4 cycles after accept.
//  2 s=0xFFFFFFFF, c=0x00000001 -> res=0x00000001, ovf=1 (carry ripples through all 4 chunks).
//  3 s=0x12345678, c=0x80000000 -> res=0x12345678, ovf=1 (dropped top carry only).
//  4 Hold out_ready_i=0 for 5 cycles after out_valid -> res_o stable, in_ready_o=0, a new in_valid is
//    ignored; release -> IDLE next cycle.
//  5 Assert rst_ni=0 in the 2nd RUN cycle -> out_valid_o=0, res_o=0 immediately. After release,
//    in_ready_o=1 and the next op resolves correctly.
//  6 1000 random pairs with random valid/ready gaps, CHUNK in {1,8,32} -> res == (s+2c) mod 2^32,
//    ovf == (s+2c)>>32 != 0.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types, sizing helper and parameter checks for the chunk-serial carry-save resolver.
package csr_pkg;

   typedef enum logic [1:0] {
      CSR_IDLE,
      CSR_RUN,
      CSR_DONE
   } csr_state_e;

   localparam int unsigned CSR_WIDTH_DEF = 32;
   localparam int unsigned CSR_CHUNK_DEF = 8;

   function automatic int unsigned csr_nch(input int unsigned width, input int unsigned chunk);
      return width / chunk;
   endfunction

   function automatic bit csr_params_ok(input int unsigned width, input int unsigned chunk);
      return (chunk != 0) && (width >= 2) && (chunk <= width) && ((width % chunk) == 0);
   endfunction

endpackage

// File: rtl/csr_chunk_add.sv
// Combinational CHUNK-bit ripple-carry adder built from full-adder cells.
module csr_chunk_add #(
   parameter int unsigned CHUNK = 8
) (
   input  logic [CHUNK-1:0] a_i,
   input  logic [CHUNK-1:0] b_i,
   input  logic             ci_i,
   output logic [CHUNK-1:0] s_o,
   output logic             co_o
);

   logic [CHUNK:0] c;

   assign c[0] = ci_i;

   for (genvar i = 0; i < CHUNK; i++) begin : g_fa
      assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
   end

   assign co_o = c[CHUNK];

endmodule

// File: rtl/cs_resolve_serial.sv
// Resolves a carry-save pair into binary, one CHUNK-bit slice per cycle.
// Optional overflow flag port ovf_o is built when CSR_OVF_EN is defined.
module cs_resolve_serial
   import csr_pkg::*;
#(
   parameter int unsigned WIDTH = CSR_WIDTH_DEF,
   parameter int unsigned CHUNK = CSR_CHUNK_DEF
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [WIDTH-1:0] s_i,
   input  logic [WIDTH-1:0] c_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [WIDTH-1:0] res_o
`ifdef CSR_OVF_EN
   ,
   output logic             ovf_o
`endif
);

   localparam int unsigned NCH   = csr_nch(WIDTH, CHUNK);
   localparam int unsigned CNT_W = (NCH > 1) ? $clog2(NCH) : 1;

   if (!csr_params_ok(WIDTH, CHUNK)) begin : g_param_chk
      $error("cs_resolve_serial: WIDTH must be >= 2 and a multiple of CHUNK");
   end

   csr_state_e       state_q, state_d;
   logic [WIDTH-1:0] s_q, s_d;
   logic [WIDTH-1:0] csh_q, csh_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cy_q, cy_d;
   logic             valid_q, valid_d;
   logic             ready_q, ready_d;
   logic             last_c;

   logic [CHUNK-1:0] a_c, b_c, sum_c;
   logic             co_c;

`ifdef CSR_OVF_EN
   logic             top_q, top_d;
   logic             ovf_q, ovf_d;
`else
   logic             unused_top_c;
   assign unused_top_c = c_i[WIDTH-1];
`endif

   // Select the active chunk of the two operands.
   always_comb begin
      a_c = '0;
      b_c = '0;
      for (int unsigned k = 0; k < NCH; k++) begin
         if (cnt_q == CNT_W'(k)) begin
            a_c = s_q[k*CHUNK +: CHUNK];
            b_c = csh_q[k*CHUNK +: CHUNK];
         end
      end
   end

   assign last_c = (cnt_q == CNT_W'(NCH - 1));

   csr_chunk_add #(.CHUNK(CHUNK)) u_add (
      .a_i  (a_c),
      .b_i  (b_c),
      .ci_i (cy_q),
      .s_o  (sum_c),
      .co_o (co_c)
   );

   // Next-state and datapath updates.
   always_comb begin
      state_d = state_q;
      s_d     = s_q;
      csh_d   = csh_q;
      res_d   = res_q;
      cnt_d   = cnt_q;
      cy_d    = cy_q;
      valid_d = valid_q;
      ready_d = ready_q;
`ifdef CSR_OVF_EN
      top_d   = top_q;
      ovf_d   = ovf_q;
`endif
      unique case (state_q)
         CSR_IDLE: begin
            if (in_valid_i && ready_q) begin
               s_d     = s_i;
               csh_d   = {c_i[WIDTH-2:0], 1'b0};
               cnt_d   = '0;
               cy_d    = 1'b0;
               ready_d = 1'b0;
               state_d = CSR_RUN;
`ifdef CSR_OVF_EN
               top_d   = c_i[WIDTH-1];
`endif
            end
         end
         CSR_RUN: begin
            for (int unsigned k = 0; k < NCH; k++) begin
               if (cnt_q == CNT_W'(k)) begin
                  res_d[k*CHUNK +: CHUNK] = sum_c;
               end
            end
            cy_d = co_c;
            if (last_c) begin
               valid_d = 1'b1;
               state_d = CSR_DONE;
`ifdef CSR_OVF_EN
               ovf_d   = co_c | top_q;
`endif
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         CSR_DONE: begin
            if (out_ready_i) begin
               valid_d = 1'b0;
               ready_d = 1'b1;
               state_d = CSR_IDLE;
            end
         end
         default: begin
            state_d = CSR_IDLE;
            valid_d = 1'b0;
            ready_d = 1'b1;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= CSR_IDLE;
         s_q     <= '0;
         csh_q   <= '0;
         res_q   <= '0;
         cnt_q   <= '0;
         cy_q    <= 1'b0;
         valid_q <= 1'b0;
         ready_q <= 1'b1;
`ifdef CSR_OVF_EN
         top_q   <= 1'b0;
         ovf_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         s_q     <= s_d;
         csh_q   <= csh_d;
         res_q   <= res_d;
         cnt_q   <= cnt_d;
         cy_q    <= cy_d;
         valid_q <= valid_d;
         ready_q <= ready_d;
`ifdef CSR_OVF_EN
         top_q   <= top_d;
         ovf_q   <= ovf_d;
`endif
      end
   end

   assign in_ready_o  = ready_q;
   assign out_valid_o = valid_q;
   assign res_o       = res_q;
`ifdef CSR_OVF_EN
   assign ovf_o       = ovf_q;
`endif

endmodule

// File: tb/tb_cs_resolve_serial.sv
// Directed-vector and randomized bench for cs_resolve_serial at CHUNK = 8, 1 and 32.
module tb_cs_resolve_serial;

   localparam int unsigned W = 32;

   logic        clk;
   logic        rst_n;
   logic        iv   [3];
   logic        ir   [3];
   logic        ov   [3];
   logic        ordy [3];
   logic [W-1:0] s_a  [3];
   logic [W-1:0] c_a  [3];
   logic [W-1:0] res_a[3];
   logic        ovf_a[3];

   int checks;
   int errors;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      localparam int unsigned CH = (g == 0) ? 8 : ((g == 1) ? 1 : 32);
      cs_resolve_serial #(.WIDTH(W), .CHUNK(CH)) u_dut (
         .clk_i       (clk),
         .rst_ni      (rst_n),
         .in_valid_i  (iv[g]),
         .in_ready_o  (ir[g]),
         .s_i         (s_a[g]),
         .c_i         (c_a[g]),
         .out_valid_o (ov[g]),
         .out_ready_i (ordy[g]),
         .res_o       (res_a[g])
`ifdef CSR_OVF_EN
         ,
         .ovf_o       (ovf_a[g])
`endif
      );
`ifndef CSR_OVF_EN
      assign ovf_a[g] = 1'b0;
`endif
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int nch_of(input int d);
      return (d == 0) ? 4 : ((d == 1) ? 32 : 1);
   endfunction

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Present an operand pair and wait (bounded) until it is accepted.
   task automatic start_op(input int d, input logic [W-1:0] s, input logic [W-1:0] c, input int gap);
      int n;
      repeat (gap) @(negedge clk);
      iv[d]  = 1'b1;
      s_a[d] = s;
      c_a[d] = c;
      n = 0;
      while (!ir[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      @(negedge clk);
      iv[d]  = 1'b0;
      s_a[d] = $urandom;
      c_a[d] = $urandom;
   endtask

   // Wait for the result, check latency/value, optionally stall, then complete the handshake.
   task automatic finish_op(input int d, input logic [W-1:0] er, input logic eo, input int hold);
      int n;
      n = 0;
      while (!ov[d] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("latency", 32'(n), 32'(nch_of(d)));
      chk("res", res_a[d], er);
`ifdef CSR_OVF_EN
      chk("ovf", 32'(ovf_a[d]), 32'(eo));
`else
      if (eo === 1'bx) chk("ovf_x", 32'd0, 32'd1);
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("hold_res", res_a[d], er);
      end
      ordy[d] = 1'b1;
      @(negedge clk);
      ordy[d] = 1'b0;
      chk("post_hs_valid", 32'(ov[d]), 32'd0);
      chk("post_hs_ready", 32'(ir[d]), 32'd1);
   endtask

   typedef struct {
      logic [W-1:0] s;
      logic [W-1:0] c;
      logic [W-1:0] res;
      logic         ovf;
   } vec_t;

   vec_t vecs[8];

   initial begin
      logic [33:0] full;
      checks = 0;
      errors = 0;
      rst_n  = 1'b0;
      for (int d = 0; d < 3; d++) begin
         iv[d] = 1'b0; ordy[d] = 1'b0; s_a[d] = '0; c_a[d] = '0;
      end

      vecs[0] = '{32'h0000_00FF, 32'h0000_0001, 32'h0000_0101, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b1};
      vecs[2] = '{32'h1234_5678, 32'h8000_0000, 32'h1234_5678, 1'b1};
      vecs[3] = '{32'h0000_0000, 32'h0000_0000, 32'h0000_0000, 1'b0};
      vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b1};
      vecs[5] = '{32'h0000_FFFF, 32'h0000_8000, 32'h0001_FFFF, 1'b0};
      vecs[6] = '{32'h7FFF_FFFF, 32'h4000_0000, 32'hFFFF_FFFF, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};

      #12;
      chk("rst_ready", 32'(ir[0]), 32'd1);
      chk("rst_valid", 32'(ov[0]), 32'd0);
      chk("rst_res", res_a[0], 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("idle_ready", 32'(ir[0]), 32'd1);

      // Directed table on the CHUNK=8 instance.
      for (int i = 0; i < 8; i++) begin
         start_op(0, vecs[i].s, vecs[i].c, 0);
         finish_op(0, vecs[i].res, vecs[i].ovf, 0);
      end

      // Output stall: result stable, inputs ignored, return to IDLE after release.
      start_op(0, 32'h1111_1111, 32'h0101_0101, 1);
      finish_op(0, 32'h1313_1313, 1'b0, 0);
      start_op(0, 32'h0000_0F00, 32'h0000_0080, 0);
      begin
         int n;
         n = 0;
         while (!ov[0] && n < 100) begin
            @(negedge clk);
            n++;
         end
         chk("stall_latency", 32'(n), 32'd4);
      end
      for (int i = 0; i < 5; i++) begin
         iv[0] = 1'b1; s_a[0] = 32'hDEAD_BEEF; c_a[0] = 32'h0BAD_F00D;
         @(negedge clk);
         chk("stall_res", res_a[0], 32'h0000_1000);
         chk("stall_ready", 32'(ir[0]), 32'd0);
         chk("stall_valid", 32'(ov[0]), 32'd1);
      end
      ordy[0] = 1'b1;
      @(negedge clk);
      ordy[0] = 1'b0;
      iv[0]   = 1'b0;
      chk("release_valid", 32'(ov[0]), 32'd0);
      chk("release_ready", 32'(ir[0]), 32'd1);
      repeat (3) begin
         @(negedge clk);
         chk("no_capture_ready", 32'(ir[0]), 32'd1);
         chk("no_capture_res", res_a[0], 32'h0000_1000);
      end

      // Reset during the second RUN cycle discards the operation.
      start_op(0, 32'hFFFF_FFFF, 32'h0000_0001, 0);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk("midrst_valid", 32'(ov[0]), 32'd0);
      chk("midrst_res", res_a[0], 32'd0);
      chk("midrst_ready", 32'(ir[0]), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("postrst_ready", 32'(ir[0]), 32'd1);
      chk("postrst_valid", 32'(ov[0]), 32'd0);
      start_op(0, 32'h1234_5678, 32'h8000_0000, 0);
      finish_op(0, 32'h1234_5678, 1'b1, 0);

      // Random pairs across CHUNK = 8, 1, 32 with input and output gaps.
      for (int i = 0; i < 1000; i++) begin
         int d;
         logic [W-1:0] rs, rc;
         d  = i % 3;
         rs = $urandom;
         rc = $urandom;
         if (i % 17 == 0) rs = 32'hFFFF_FFFF;
         full = {2'b00, rs} + ({2'b00, rc} << 1);
         start_op(d, rs, rc, int'($urandom_range(0, 3)));
         finish_op(d, full[W-1:0], |full[33:32], int'($urandom_range(0, 2)));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
